// File: rtl/branch_resolver_if.sv
// ============================================================================
// Module   : branch_resolver_if
// Purpose  : Issue, execute and resolution signals between pipeline and resolver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_resolver_if;
  logic        isBranch;
  logic [31:0] branchPC;
  logic [2:0]  branchT;
  logic        predictTaken;
  logic [3:0]  confidence;
  logic        exValid;
  logic [31:0] exPC;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic        pipeFlush;
  logic        issueStall;
  logic        branchResolved;
  logic        actualTaken;
  logic [31:0] resolvedPC;
  logic        mispredict;
  logic        orderError;
  logic        overflow;
  logic [15:0] mispredictCount;
  logic [15:0] hiConfMispredicts;

  modport master (
    output isBranch, branchPC, branchT, predictTaken, confidence,
           exValid, exPC, rs1Data, rs2Data, pipeFlush,
    input  issueStall, branchResolved, actualTaken, resolvedPC, mispredict,
           orderError, overflow, mispredictCount, hiConfMispredicts
  );

  modport slave (
    input  isBranch, branchPC, branchT, predictTaken, confidence,
           exValid, exPC, rs1Data, rs2Data, pipeFlush,
    output issueStall, branchResolved, actualTaken, resolvedPC, mispredict,
           orderError, overflow, mispredictCount, hiConfMispredicts
  );
endinterface

`default_nettype wire

// File: rtl/branch_resolver.sv
// ============================================================================
// Module   : branch_resolver
// Purpose  : In-order branch outcome resolver; optional BRANCH_CONF_STATS_EN
//            adds per-entry confidence and a high-confidence mispredict count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolver #(
  parameter int DEPTH   = 4,
  parameter int CONF_HI = 12
) (
  input  wire logic       clk,
  input  wire logic       resetN,
  branch_resolver_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic          r_pendValid;
  logic [31:0]   r_pendPC;
  logic [2:0]    r_pendT;
  logic [AW-1:0] r_headPtr;
  logic [AW-1:0] r_tailPtr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_qPC   [DEPTH];
  logic [2:0]    r_qT    [DEPTH];
  logic          r_qPred [DEPTH];

  logic          r_resolved;
  logic          r_actual;
  logic [31:0]   r_resPC;
  logic          r_misp;
  logic          r_orderErr;
  logic          r_overflow;
  logic [15:0]   r_misCount;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [31:0]   w_headPC;
  logic [2:0]    w_headT;
  logic          w_headPred;
  logic          w_taken;
  logic          w_badType;
  logic          w_ordErr;
  logic          w_misp;

  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);
  assign w_pop   = bus.exValid && !w_empty;
  // A full queue still accepts the pending branch if the head leaves this cycle.
  assign w_push  = r_pendValid && (!w_full || w_pop);
  assign w_drop  = r_pendValid && w_full && !w_pop;

  assign bus.issueStall = (r_count + CW'(r_pendValid)) >= c_depth;

  // An empty queue resolves as a not-predicted BEQ with no valid PC.
  assign w_headPC   = w_empty ? 32'h0 : r_qPC[r_headPtr];
  assign w_headT    = w_empty ? 3'b000 : r_qT[r_headPtr];
  assign w_headPred = w_empty ? 1'b0 : r_qPred[r_headPtr];

  always_comb begin
    w_taken   = 1'b0;
    w_badType = 1'b0;
    case (w_headT)
      3'b000:  w_taken = (bus.rs1Data == bus.rs2Data);
      3'b001:  w_taken = (bus.rs1Data != bus.rs2Data);
      3'b100:  w_taken = ($signed(bus.rs1Data) <  $signed(bus.rs2Data));
      3'b101:  w_taken = ($signed(bus.rs1Data) >= $signed(bus.rs2Data));
      3'b110:  w_taken = (bus.rs1Data <  bus.rs2Data);
      3'b111:  w_taken = (bus.rs1Data >= bus.rs2Data);
      default: w_badType = 1'b1;
    endcase
  end

  assign w_ordErr = w_empty || (bus.exPC != w_headPC) || w_badType;
  assign w_misp   = (w_headPred != w_taken) || w_ordErr;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pendValid <= 1'b0;
      r_pendPC    <= 32'h0;
      r_pendT     <= 3'b000;
      r_headPtr   <= '0;
      r_tailPtr   <= '0;
      r_count     <= '0;
    end else begin
      r_pendPC <= bus.branchPC;
      r_pendT  <= bus.branchT;
      if (bus.pipeFlush) begin
        r_pendValid <= 1'b0;
        r_headPtr   <= '0;
        r_tailPtr   <= '0;
        r_count     <= '0;
      end else begin
        r_pendValid <= bus.isBranch;
        if (w_push) r_tailPtr <= r_tailPtr + 1'b1;
        if (w_pop)  r_headPtr <= r_headPtr + 1'b1;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qPC[r_tailPtr]   <= r_pendPC;
      r_qT[r_tailPtr]    <= r_pendT;
      r_qPred[r_tailPtr] <= bus.predictTaken;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_resolved <= 1'b0;
      r_actual   <= 1'b0;
      r_resPC    <= 32'h0;
      r_misp     <= 1'b0;
      r_orderErr <= 1'b0;
      r_overflow <= 1'b0;
      r_misCount <= 16'h0;
    end else begin
      r_resolved <= bus.exValid;
      if (bus.exValid) begin
        r_actual <= w_taken;
        r_resPC  <= bus.exPC;
        r_misp   <= w_misp;
        if (w_ordErr) r_orderErr <= 1'b1;
        if (w_misp && (r_misCount != 16'hFFFF)) r_misCount <= r_misCount + 16'h1;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign bus.branchResolved  = r_resolved;
  assign bus.actualTaken     = r_actual;
  assign bus.resolvedPC      = r_resPC;
  assign bus.mispredict      = r_misp;
  assign bus.orderError      = r_orderErr;
  assign bus.overflow        = r_overflow;
  assign bus.mispredictCount = r_misCount;

`ifdef BRANCH_CONF_STATS_EN
  logic [3:0]  r_qConf [DEPTH];
  logic [15:0] r_hiConf;
  logic        w_hiConfHit;

  always_ff @(posedge clk) begin
    if (w_push) r_qConf[r_tailPtr] <= bus.confidence;
  end

  assign w_hiConfHit = w_misp && !w_empty && (32'(r_qConf[r_headPtr]) >= CONF_HI);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hiConf <= 16'h0;
    end else if (bus.exValid && w_hiConfHit && (r_hiConf != 16'hFFFF)) begin
      r_hiConf <= r_hiConf + 16'h1;
    end
  end

  assign bus.hiConfMispredicts = r_hiConf;
`else
  localparam logic [3:0] c_unusedConfHi = 4'(CONF_HI);
  logic w_unusedConf;
  assign w_unusedConf = ^{bus.confidence, c_unusedConfHi};
  assign bus.hiConfMispredicts = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolver.sv
// ============================================================================
// Module   : tb_branch_resolver
// Purpose  : Scoreboard bench for branch_resolver (DEPTH=4, CONF_HI=12).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolver;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  branch_resolver_if bus ();

  branch_resolver #(.DEPTH(DEPTH), .CONF_HI(12)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  typedef struct { logic [31:0] pc; logic [2:0] t; logic pred; logic [3:0] conf; } ent_t;
  typedef struct { logic [31:0] pc; logic taken; logic mis; } res_t;

  ent_t mq[$];
  res_t sbq[$];
  ent_t pend;
  bit   pendV = 0;

  int vecCount = 0;
  int missCount = 0;
  int resCount = 0;
  int expResCount = 0;
  logic [15:0] expMis = 0;
  logic [15:0] expHi = 0;
  logic expOverflow = 0;
  logic expOrderErr = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic outcome(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return !($signed(a) < $signed(b));
      3'b110:  return a < b;
      3'b111:  return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  // One cycle of stimulus; the model state afterwards matches the DUT after the next posedge.
  task automatic drive(input bit isB, input logic [31:0] pc, input logic [2:0] t,
                       input bit pred, input logic [3:0] conf, input bit exV,
                       input logic [31:0] xpc, input logic [31:0] a, input logic [31:0] b,
                       input bit flush);
    ent_t e;
    res_t r;
    bit   empty;
    bit   oe;
    @(negedge clk);
    bus.isBranch     = isB;
    bus.branchPC     = pc;
    bus.branchT      = t;
    bus.predictTaken = pendV ? pend.pred : 1'b0;
    bus.confidence   = pendV ? pend.conf : 4'h0;
    bus.exValid      = exV;
    bus.exPC         = xpc;
    bus.rs1Data      = a;
    bus.rs2Data      = b;
    bus.pipeFlush    = flush;
    if (exV) begin
      empty = (mq.size() == 0);
      e = empty ? '{32'h0, 3'b000, 1'b0, 4'h0} : mq.pop_front();
      r.pc    = xpc;
      r.taken = outcome(e.t, a, b);
      oe      = empty || (xpc != e.pc) || (e.t == 3'b010) || (e.t == 3'b011);
      r.mis   = (e.pred != r.taken) || oe;
      if (oe) expOrderErr = 1'b1;
      if (r.mis && expMis != 16'hFFFF) expMis++;
      if (r.mis && !empty && e.conf >= 4'd12) expHi++;
      sbq.push_back(r);
      expResCount++;
    end
    if (pendV) begin
      if (mq.size() < DEPTH) mq.push_back(pend);
      else expOverflow = 1'b1;
    end
    if (flush) begin
      mq.delete();
      pendV = 0;
    end else begin
      pendV = isB;
      pend  = '{pc, t, pred, conf};
    end
  endtask

  task automatic issue(input logic [31:0] pc, input logic [2:0] t, input bit pred, input logic [3:0] conf);
    drive(1, pc, t, pred, conf, 0, 32'h0, 32'h0, 32'h0, 0);
  endtask

  task automatic idle();
    drive(0, 32'h0, 3'b000, 0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 0);
  endtask

  task automatic resolve(input logic [31:0] xpc, input logic [31:0] a, input logic [31:0] b);
    drive(0, 32'h0, 3'b000, 0, 4'h0, 1, xpc, a, b, 0);
  endtask

  always @(negedge clk) begin
    res_t r;
    if (resetN && bus.branchResolved) begin
      resCount++;
      if (sbq.size() == 0) begin
        checkVal("spuriousResolve", 32'd1, 32'd0);
      end else begin
        r = sbq.pop_front();
        checkVal("resolvedPC", bus.resolvedPC, r.pc);
        checkVal("actualTaken", 32'(bus.actualTaken), 32'(r.taken));
        checkVal("mispredict", 32'(bus.mispredict), 32'(r.mis));
      end
    end
  end

  initial begin
    bus.isBranch = 0; bus.branchPC = 0; bus.branchT = 0; bus.predictTaken = 0;
    bus.confidence = 0; bus.exValid = 0; bus.exPC = 0; bus.rs1Data = 0;
    bus.rs2Data = 0; bus.pipeFlush = 0;
    repeat (2) @(negedge clk);
    checkVal("rstStall", 32'(bus.issueStall), 32'd0);
    checkVal("rstResolved", 32'(bus.branchResolved), 32'd0);
    checkVal("rstMisCnt", 32'(bus.mispredictCount), 32'd0);
    checkVal("rstOrderErr", 32'(bus.orderError), 32'd0);
    checkVal("rstOverflow", 32'(bus.overflow), 32'd0);
    resetN = 1'b1;

    // BNE taken, correctly predicted
    issue(32'h2000, 3'b001, 1, 4'h5);
    idle();
    resolve(32'h2000, 32'd5, 32'd3);
    idle(); idle();
    checkVal("bneMisCnt", 32'(bus.mispredictCount), 32'(expMis));

    // BEQ equal then unequal, both predicted taken
    issue(32'h1000, 3'b000, 1, 4'h5);
    issue(32'h1004, 3'b000, 1, 4'h5);
    idle();
    resolve(32'h1000, 32'd7, 32'd7);
    idle();
    checkVal("beqHitMisCnt", 32'(bus.mispredictCount), 32'd0);
    resolve(32'h1004, 32'd7, 32'd8);
    idle();
    checkVal("beqMissMisCnt", 32'(bus.mispredictCount), 32'd1);

    // Signed vs unsigned compares with -1 vs 1
    issue(32'h1100, 3'b100, 0, 4'h0);
    issue(32'h1104, 3'b110, 0, 4'h0);
    issue(32'h1108, 3'b101, 0, 4'h0);
    issue(32'h110C, 3'b111, 0, 4'h0);
    idle();
    resolve(32'h1100, 32'hFFFF_FFFF, 32'd1);
    resolve(32'h1104, 32'hFFFF_FFFF, 32'd1);
    resolve(32'h1108, 32'hFFFF_FFFF, 32'd1);
    resolve(32'h110C, 32'hFFFF_FFFF, 32'd1);
    idle(); idle();
    checkVal("cmpMisCnt", 32'(bus.mispredictCount), 32'(expMis));

    // Five back-to-back branches into a four-entry queue
    for (int k = 0; k < 5; k++) issue(32'h6000 + 32'(4 * k), 3'b000, 0, 4'h0);
    idle();
    checkVal("fullStall", 32'(bus.issueStall), 32'd1);
    checkVal("preOverflow", 32'(bus.overflow), 32'd0);
    idle();
    checkVal("overflow", 32'(bus.overflow), 32'(expOverflow));
    checkVal("fullStall2", 32'(bus.issueStall), 32'd1);
    for (int k = 0; k < 4; k++) resolve(32'h6000 + 32'(4 * k), 32'd1, 32'd2);
    idle();
    checkVal("drainStall", 32'(bus.issueStall), 32'd0);

    // Flush with three entries queued
    issue(32'h4000, 3'b001, 1, 4'h0);
    issue(32'h4004, 3'b001, 1, 4'h0);
    issue(32'h4008, 3'b001, 1, 4'h0);
    idle();
    drive(0, 32'h0, 3'b000, 0, 4'h0, 0, 32'h0, 32'h0, 32'h0, 1);
    idle();
    checkVal("flushStall", 32'(bus.issueStall), 32'd0);
    checkVal("flushMisCnt", 32'(bus.mispredictCount), 32'(expMis));
    checkVal("flushOverflow", 32'(bus.overflow), 32'd1);
    issue(32'h4100, 3'b001, 1, 4'h0);
    idle();
    resolve(32'h4100, 32'd1, 32'd2);
    idle(); idle();
    checkVal("postFlushOrderErr", 32'(bus.orderError), 32'd0);

    // Confidence statistics
    issue(32'h7000, 3'b000, 1, 4'd13);
    issue(32'h7004, 3'b000, 1, 4'd4);
    idle();
    resolve(32'h7000, 32'd1, 32'd2);
    resolve(32'h7004, 32'd1, 32'd2);
    idle();
`ifdef BRANCH_CONF_STATS_EN
    checkVal("hiConf", 32'(bus.hiConfMispredicts), 32'(expHi));
`else
    checkVal("hiConfTied", 32'(bus.hiConfMispredicts), 32'd0);
`endif

    // PC mismatch, then resolve with empty queue
    issue(32'h3000, 3'b000, 1, 4'h0);
    idle();
    resolve(32'h3004, 32'd7, 32'd7);
    idle();
    checkVal("pcOrderErr", 32'(bus.orderError), 32'(expOrderErr));
    resolve(32'h3008, 32'd1, 32'd1);
    idle();
    checkVal("emptyOrderErr", 32'(bus.orderError), 32'd1);
    checkVal("errMisCnt", 32'(bus.mispredictCount), 32'(expMis));

    // Asynchronous reset while a resolution is about to register
    issue(32'h5000, 3'b000, 0, 4'h0);
    idle();
    @(negedge clk);
    bus.exValid = 1'b1; bus.exPC = 32'h5000;
    #2 resetN = 1'b0;
    #1;
    checkVal("arstMisCnt", 32'(bus.mispredictCount), 32'd0);
    checkVal("arstOrderErr", 32'(bus.orderError), 32'd0);
    @(posedge clk); #1;
    checkVal("arstResolved", 32'(bus.branchResolved), 32'd0);
    @(negedge clk);
    bus.exValid = 1'b0;
    resetN = 1'b1;
    mq.delete(); pendV = 0;
    expMis = 0; expHi = 0; expOverflow = 0; expOrderErr = 0;

    issue(32'h8000, 3'b001, 0, 4'h0);
    idle();
    resolve(32'h8000, 32'd1, 32'd2);
    idle(); idle(); idle();
    checkVal("finalMisCnt", 32'(bus.mispredictCount), 32'(expMis));
    checkVal("finalOverflow", 32'(bus.overflow), 32'(expOverflow));
    checkVal("sbEmpty", 32'(sbq.size()), 32'd0);
    checkVal("resCount", 32'(resCount), 32'(expResCount));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule

`default_nettype wire
